dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Linear frequency-sweep (chirp) sequencer that drives the phase input of the dds block.
//  Holds a phase accumulator and a frequency tuning word (FTW). Steps the FTW from start to stop
//  every DWELL accepted samples. Emits a phase-continuous AXI-stream phase word per accepted sample.
//  Sits between the register/control plane and dds.s_axis_phase_*.
// PARAMETERS
//  PHASE_DW  16  phase word / accumulator width (matches dds PHASE_DW)
//  FREQ_DW   16  FTW width, <= PHASE_DW; zero-extended into accumulator adds
//  DWELL_DW  16  dwell counter width (samples per frequency step)
//  CNT_DW    16  completed-sweep counter width
// PORTS
//  clk                 in   1         clock
//  reset               in   1         asynchronous reset, active-high
//  cfg_start_ftw       in   FREQ_DW   first FTW of sweep
//  cfg_stop_ftw        in   FREQ_DW   last allowed FTW (inclusive)
//  cfg_step_ftw        in   FREQ_DW   FTW increment per dwell period
//  cfg_dwell           in   DWELL_DW  samples per FTW; 0 treated as 1
//  cfg_phase_offset    in   PHASE_DW  constant added to every output phase
//  cfg_continuous      in   1         0: single sweep, 1: repeat until abort
//  start               in   1         pulse; starts sweep when idle
//  abort               in   1         pulse; terminates sweep
//  m_axis_phase_tdata  out  PHASE_DW  phase word to dds
//  m_axis_phase_tvalid out  1         phase word valid
//  m_axis_phase_tready in   1         sink ready; tie 1 for dds
//  busy                out  1         high in LOAD/SWEEP
//  sweep_done          out  1         1-cycle pulse at end of each sweep
//  sweep_count         out  CNT_DW    sweeps completed since start, saturating
// BEHAVIOUR
//  Reset: state IDLE. Accumulator, FTW and dwell counter are 0. All outputs 0.
//  FSM IDLE -> LOAD -> SWEEP -> DONE -> IDLE.
//  IDLE: tvalid=0. When start=1 and abort=0:
//    - shadow-latch all cfg_* inputs; cfg changes mid-sweep are ignored
//    - clear sweep_count; go to LOAD.
//  LOAD (1 cycle): acc=0, ftw=start_ftw, dwell_cnt=0, tdata=phase_offset; go to SWEEP.
//  Latency: start sampled at edge t -> tvalid=1 at t+2 with tdata=phase_offset.
//  SWEEP: tvalid=1; tdata is registered and always equals acc+phase_offset (mod 2^PHASE_DW).
//    - Handshake (tvalid&tready): acc+=ftw (mod 2^PHASE_DW); dwell_cnt++.
//    - No handshake: tdata, acc and counters hold.
//    - End of dwell: handshake with dwell_cnt==max(dwell,1)-1. Then dwell_cnt=0.
//    - Sweep end: step==0, OR ftw+step > stop (compare in FREQ_DW+1 bits; no wrap),
//      OR start_ftw > stop_ftw. Otherwise ftw+=step.
//    - At sweep end: sweep_done pulses; sweep_count++ (saturating at all-ones).
//      continuous=1: ftw=start_ftw; acc is not reset (phase-continuous); stay in SWEEP.
//      continuous=0: go to DONE.
//  DONE (1 cycle): tvalid=0, busy=0; go to IDLE.
//  start while busy: ignored. start and abort in the same cycle: abort wins.
//  abort in LOAD/SWEEP: next cycle IDLE, tvalid=0, no sweep_done pulse; sweep_count holds.
//  The tvalid drop without tready on abort is permitted (dds has no backpressure).
//  Async reset mid-sweep: immediate return to reset values.
// CONFIGURATION
//  `DDS_SWEEP_TRIANGLE_EN` defined:
//    - adds a direction flag.
//    - continuous=1: at stop the FTW reverses and steps down to start_ftw, then up again.
//    - sweep_done pulses at each turn-around.
//    - In a single sweep (continuous=0) it ends at stop, as without the macro.
//  `DDS_SWEEP_TRIANGLE_EN` not defined: sawtooth only; no direction logic is synthesized.
// STRUCTURE
//  dds_pkg: sweep_state_t enum {IDLE,LOAD,SWEEP,DONE}; sweep_dir_t {UP,DOWN};
//    sweep_cfg_t struct (shadowed cfg fields).
//  Sub-module dds_phase_acc: phase accumulator with enable, sync clear,
//    registered offset add; PHASE_DW/FREQ_DW params.
// TESTING
//  Sample counts below are accepted samples (handshakes).
//  T1 Basic ramp: start=100, stop=400, step=100, dwell=2, offset=0, tready=1.
//     -> 8 samples; phase = 0,100,200,400,600,900,1200,1600; sweep_done after 8th; DONE->IDLE.
//  T2 Backpressure: same cfg, tready toggling 1,0,0,1.
//     -> tdata stable while tready=0; same phase sequence as T1; sample count unchanged.
//  T3 Continuous wrap: PHASE_DW=16, start=stop=0x4000, dwell=1, continuous=1.
//     -> phase 0,0x4000,0x8000,0xC000,0x0000 (wrap); sweep_done every sample; sweep_count 1,2,3...
//  T4 Abort/start collision: abort mid-SWEEP.
//     -> tvalid=0 next cycle, no sweep_done. start&abort in IDLE -> stays IDLE.
//  T5 Edge cfg: step=0, dwell=0, start=50.
//     -> exactly 1 sample (phase=offset), then done.
//     start=500 > stop=100, dwell=3 -> 3 samples at ftw 500, then done.
//  T6 Async reset mid-sweep, and (macro on) triangle start=100, stop=300, step=100, dwell=1.
//     -> ftw sequence 100,200,300,200,100,200...

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and helpers for the DDS frequency-sweep sequencer.
package dds_sweep_ctrl_pkg;

    localparam int SWEEP_PHASE_DW = 16;
    localparam int SWEEP_FREQ_DW  = 16;
    localparam int SWEEP_DWELL_DW = 16;
    localparam int SWEEP_CNT_DW   = 16;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} sweep_state_t;
    typedef enum logic {UP, DOWN} sweep_dir_t;

    typedef struct packed {
        logic [SWEEP_FREQ_DW-1:0]  start_ftw;
        logic [SWEEP_FREQ_DW-1:0]  stop_ftw;
        logic [SWEEP_FREQ_DW-1:0]  step_ftw;
        logic [SWEEP_DWELL_DW-1:0] dwell;
        logic [SWEEP_PHASE_DW-1:0] phase_offset;
        logic                      continuous;
    } sweep_cfg_t;

    // One extra bit so a step near the top of the FTW range cannot wrap past stop.
    function automatic logic ftw_past_stop(input logic [SWEEP_FREQ_DW-1:0] ftw,
                                           input logic [SWEEP_FREQ_DW-1:0] step,
                                           input logic [SWEEP_FREQ_DW-1:0] stop);
        return ({1'b0, ftw} + {1'b0, step}) > {1'b0, stop};
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// AXI-stream phase channel between the sweep sequencer and the dds block.
interface dds_sweep_ctrl_if
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_DW = SWEEP_PHASE_DW
);
    logic [PHASE_DW-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dds_sweep_ctrl_phase_acc.sv
// Phase accumulator with sync clear and a registered phase-offset add.
module dds_sweep_ctrl_phase_acc
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_DW = SWEEP_PHASE_DW,
    parameter int FREQ_DW  = SWEEP_FREQ_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_en,
    input  logic [FREQ_DW-1:0]  i_ftw,
    input  logic [PHASE_DW-1:0] i_offset,
    output logic [PHASE_DW-1:0] o_phase
);
    logic [PHASE_DW-1:0] r_acc;
    logic [PHASE_DW-1:0] r_phase;
    logic [PHASE_DW-1:0] w_acc_next;

    assign w_acc_next = r_acc + PHASE_DW'(i_ftw);
    assign o_phase    = r_phase;

    // The output register tracks acc+offset so tdata never lags the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_phase <= i_offset;
        end else if (i_en) begin
            r_acc   <= w_acc_next;
            r_phase <= w_acc_next + i_offset;
        end
    end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear chirp sequencer feeding phase words to the dds block.
// Define DDS_SWEEP_TRIANGLE_EN for up/down (triangle) sweeps in continuous mode.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_DW = SWEEP_PHASE_DW,
    parameter int FREQ_DW  = SWEEP_FREQ_DW,
    parameter int DWELL_DW = SWEEP_DWELL_DW,
    parameter int CNT_DW   = SWEEP_CNT_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FREQ_DW-1:0]    cfg_start_ftw,
    input  logic [FREQ_DW-1:0]    cfg_stop_ftw,
    input  logic [FREQ_DW-1:0]    cfg_step_ftw,
    input  logic [DWELL_DW-1:0]   cfg_dwell,
    input  logic [PHASE_DW-1:0]   cfg_phase_offset,
    input  logic                  cfg_continuous,
    input  logic                  start,
    input  logic                  abort,
    dds_sweep_ctrl_if.master      m_axis_phase,
    output logic                  busy,
    output logic                  sweep_done,
    output logic [CNT_DW-1:0]     sweep_count
);
    sweep_state_t        r_state;
    sweep_cfg_t          r_cfg;
    logic [FREQ_DW-1:0]  r_ftw;
    logic [DWELL_DW-1:0] r_dwell_cnt;
    logic                r_tvalid;
    logic                r_busy;
    logic                r_sweep_done;
    logic [CNT_DW-1:0]   r_sweep_count;

    logic                w_hs;
    logic                w_dwell_last;
    logic [DWELL_DW-1:0] w_dwell_max;
    logic                w_degenerate;
    logic                w_up_end;
    logic                w_end;
    logic [PHASE_DW-1:0] w_phase;

    assign w_hs         = (r_state == SWEEP) && r_tvalid && m_axis_phase.tready;
    assign w_dwell_max  = (r_cfg.dwell == '0) ? '0 : r_cfg.dwell - DWELL_DW'(1);
    assign w_dwell_last = (r_dwell_cnt == w_dwell_max);
    assign w_degenerate = (r_cfg.step_ftw == '0) || (r_cfg.start_ftw > r_cfg.stop_ftw);
    assign w_up_end     = w_degenerate || ftw_past_stop(r_ftw, r_cfg.step_ftw, r_cfg.stop_ftw);

`ifdef DDS_SWEEP_TRIANGLE_EN
    sweep_dir_t r_dir;
    logic       w_down_end;

    // Descending turns around when another step would drop below start_ftw.
    assign w_down_end = w_degenerate ||
                        ({1'b0, r_ftw} < ({1'b0, r_cfg.start_ftw} + {1'b0, r_cfg.step_ftw}));
    assign w_end      = (r_dir == DOWN) ? w_down_end : w_up_end;
`else
    assign w_end      = w_up_end;
`endif

    dds_sweep_ctrl_phase_acc #(
        .PHASE_DW (PHASE_DW),
        .FREQ_DW  (FREQ_DW)
    ) u_phase_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == LOAD),
        .i_en     (w_hs && !abort),
        .i_ftw    (r_ftw),
        .i_offset (r_cfg.phase_offset),
        .o_phase  (w_phase)
    );

    assign m_axis_phase.tdata  = w_phase;
    assign m_axis_phase.tvalid = r_tvalid;
    assign busy                = r_busy;
    assign sweep_done          = r_sweep_done;
    assign sweep_count         = r_sweep_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cfg         <= '0;
            r_ftw         <= '0;
            r_dwell_cnt   <= '0;
            r_tvalid      <= 1'b0;
            r_busy        <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_sweep_count <= '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            r_dir         <= UP;
`endif
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_cfg <= '{start_ftw: cfg_start_ftw, stop_ftw: cfg_stop_ftw,
                                   step_ftw: cfg_step_ftw, dwell: cfg_dwell,
                                   phase_offset: cfg_phase_offset, continuous: cfg_continuous};
                        r_sweep_count <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_ftw       <= r_cfg.start_ftw;
                        r_dwell_cnt <= '0;
                        r_tvalid    <= 1'b1;
                        r_state     <= SWEEP;
`ifdef DDS_SWEEP_TRIANGLE_EN
                        r_dir       <= UP;
`endif
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        r_tvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_hs && !w_dwell_last) begin
                        r_dwell_cnt <= r_dwell_cnt + DWELL_DW'(1);
                    end else if (w_hs && !w_end) begin
                        r_dwell_cnt <= '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
                        r_ftw <= (r_dir == DOWN) ? r_ftw - r_cfg.step_ftw : r_ftw + r_cfg.step_ftw;
`else
                        r_ftw <= r_ftw + r_cfg.step_ftw;
`endif
                    end else if (w_hs) begin
                        r_dwell_cnt  <= '0;
                        r_sweep_done <= 1'b1;
                        if (r_sweep_count != '1) begin
                            r_sweep_count <= r_sweep_count + CNT_DW'(1);
                        end
                        if (r_cfg.continuous) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                            // Turn around; fall back to start_ftw when the range is too narrow to step.
                            if (w_degenerate) begin
                                r_ftw <= r_cfg.start_ftw;
                                r_dir <= UP;
                            end else if (r_dir == UP) begin
                                r_ftw <= w_down_end ? r_cfg.start_ftw : r_ftw - r_cfg.step_ftw;
                                r_dir <= DOWN;
                            end else begin
                                r_ftw <= w_up_end ? r_cfg.start_ftw : r_ftw + r_cfg.step_ftw;
                                r_dir <= UP;
                            end
`else
                            r_ftw <= r_cfg.start_ftw;
`endif
                        end else begin
                            r_tvalid <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl (sawtooth build; triangle case when DDS_SWEEP_TRIANGLE_EN is set).
module tb_dds_sweep_ctrl;
    import dds_sweep_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfgStartFtw, cfgStopFtw, cfgStepFtw, cfgDwell, cfgPhaseOffset;
    logic        cfgContinuous;
    logic        start, abort;
    logic        busy, sweepDone;
    logic [15:0] sweepCount;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [15:0] samples[$];
    logic        doneSeen;
    int          stallChanges;
    logic [15:0] got;
    logic [15:0] expRamp[8] = '{16'd0, 16'd100, 16'd200, 16'd400, 16'd600, 16'd900, 16'd1200, 16'd1600};

    dds_sweep_ctrl_if #(.PHASE_DW(16)) axisIf ();

    dds_sweep_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_start_ftw    (cfgStartFtw),
        .cfg_stop_ftw     (cfgStopFtw),
        .cfg_step_ftw     (cfgStepFtw),
        .cfg_dwell        (cfgDwell),
        .cfg_phase_offset (cfgPhaseOffset),
        .cfg_continuous   (cfgContinuous),
        .start            (start),
        .abort            (abort),
        .m_axis_phase     (axisIf),
        .busy             (busy),
        .sweep_done       (sweepDone),
        .sweep_count      (sweepCount)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task setCfg(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                input logic [15:0] d, input logic [15:0] off, input logic cont);
        cfgStartFtw    = s;
        cfgStopFtw     = e;
        cfgStepFtw     = st;
        cfgDwell       = d;
        cfgPhaseOffset = off;
        cfgContinuous  = cont;
    endtask

    task pulseStart;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records accepted samples until the first sweep_done or the cycle budget runs out.
    task captureSamples(input int maxCycles, input logic [3:0] readyPat);
        logic [15:0] prevData;
        logic        prevStall;
        samples.delete();
        doneSeen     = 1'b0;
        stallChanges = 0;
        prevStall    = 1'b0;
        prevData     = '0;
        for (int c = 0; c < maxCycles && !doneSeen; c++) begin
            axisIf.tready = readyPat[c % 4];
            if (prevStall && axisIf.tdata !== prevData) stallChanges++;
            if (axisIf.tvalid && axisIf.tready) samples.push_back(axisIf.tdata);
            prevStall = axisIf.tvalid && !axisIf.tready;
            prevData  = axisIf.tdata;
            tick();
            if (sweepDone) doneSeen = 1'b1;
        end
        axisIf.tready = 1'b1;
    endtask

    task test_reset;
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        checkCount++; if (axisIf.tdata !== 16'd0) $display("[TB] FAIL reset_tdata: got %0d want 0", axisIf.tdata); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (sweepDone !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", sweepDone); else passCount++;
        checkCount++; if (sweepCount !== 16'd0) $display("[TB] FAIL reset_count: got %0d want 0", sweepCount); else passCount++;
    endtask

    task test_basic_ramp;
        setCfg(16'd100, 16'd400, 16'd100, 16'd2, 16'd0, 1'b0);
        pulseStart();
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL load_busy: got %b want 1", busy); else passCount++;
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL load_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        tick();
        checkCount++; if (axisIf.tvalid !== 1'b1) $display("[TB] FAIL latency_tvalid: got %b want 1", axisIf.tvalid); else passCount++;
        captureSamples(40, 4'b1111);
        checkCount++; if (samples.size() !== 8) $display("[TB] FAIL ramp_count: got %0d want 8", samples.size()); else passCount++;
        for (int i = 0; i < 8; i++) begin
            got = (i < samples.size()) ? samples[i] : 16'hxxxx;
            checkCount++;
            if (got !== expRamp[i]) $display("[TB] FAIL ramp_phase[%0d]: got %0d want %0d", i, got, expRamp[i]);
            else passCount++;
        end
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL ramp_done: got %b want 1", doneSeen); else passCount++;
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL done_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL done_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (sweepCount !== 16'd1) $display("[TB] FAIL ramp_sweep_count: got %0d want 1", sweepCount); else passCount++;
        tick();
        checkCount++; if (sweepDone !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b want 0", sweepDone); else passCount++;
    endtask

    task test_backpressure;
        setCfg(16'd100, 16'd400, 16'd100, 16'd2, 16'd0, 1'b0);
        pulseStart();
        captureSamples(80, 4'b1001);
        checkCount++; if (samples.size() !== 8) $display("[TB] FAIL bp_count: got %0d want 8", samples.size()); else passCount++;
        for (int i = 0; i < 8; i++) begin
            got = (i < samples.size()) ? samples[i] : 16'hxxxx;
            checkCount++;
            if (got !== expRamp[i]) $display("[TB] FAIL bp_phase[%0d]: got %0d want %0d", i, got, expRamp[i]);
            else passCount++;
        end
        checkCount++; if (stallChanges !== 0) $display("[TB] FAIL bp_stall_stable: got %0d changes want 0", stallChanges); else passCount++;
        checkCount++; if (doneSeen !== 1'b1) $display("[TB] FAIL bp_done: got %b want 1", doneSeen); else passCount++;
        tick();
    endtask

    task test_continuous_wrap_abort;
        logic [15:0] expPhase;
        setCfg(16'h4000, 16'h4000, 16'h0100, 16'd1, 16'd0, 1'b1);
        pulseStart();
        tick();
        for (int i = 0; i < 5; i++) begin
            expPhase = 16'(i * 16'h4000);
            checkCount++;
            if (axisIf.tdata !== expPhase) $display("[TB] FAIL wrap_phase[%0d]: got %h want %h", i, axisIf.tdata, expPhase);
            else passCount++;
            tick();
            checkCount++;
            if (sweepDone !== 1'b1) $display("[TB] FAIL wrap_done[%0d]: got %b want 1", i, sweepDone); else passCount++;
            checkCount++;
            if (sweepCount !== 16'(i + 1)) $display("[TB] FAIL wrap_count[%0d]: got %0d want %0d", i, sweepCount, i + 1);
            else passCount++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL abort_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        checkCount++; if (sweepDone !== 1'b0) $display("[TB] FAIL abort_no_done: got %b want 0", sweepDone); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passCount++;
        checkCount++; if (sweepCount !== 16'd5) $display("[TB] FAIL abort_count_hold: got %0d want 5", sweepCount); else passCount++;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL collide_busy: got %b want 0", busy); else passCount++;
        tick();
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL collide_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        checkCount++; if (sweepCount !== 16'd5) $display("[TB] FAIL collide_count: got %0d want 5", sweepCount); else passCount++;
    endtask

    task test_edge_cfg;
        setCfg(16'd50, 16'd1000, 16'd0, 16'd0, 16'h1234, 1'b0);
        pulseStart();
        captureSamples(20, 4'b1111);
        checkCount++; if (samples.size() !== 1) $display("[TB] FAIL step0_count: got %0d want 1", samples.size()); else passCount++;
        got = (samples.size() > 0) ? samples[0] : 16'hxxxx;
        checkCount++; if (got !== 16'h1234) $display("[TB] FAIL step0_phase: got %h want 1234", got); else passCount++;
        checkCount++; if (sweepCount !== 16'd1) $display("[TB] FAIL step0_sweep_count: got %0d want 1", sweepCount); else passCount++;
        tick();
        setCfg(16'd500, 16'd100, 16'd10, 16'd3, 16'd0, 1'b0);
        pulseStart();
        captureSamples(20, 4'b1111);
        checkCount++; if (samples.size() !== 3) $display("[TB] FAIL inverted_count: got %0d want 3", samples.size()); else passCount++;
        for (int i = 0; i < 3; i++) begin
            got = (i < samples.size()) ? samples[i] : 16'hxxxx;
            checkCount++;
            if (got !== 16'(i * 500)) $display("[TB] FAIL inverted_phase[%0d]: got %0d want %0d", i, got, i * 500);
            else passCount++;
        end
        tick();
    endtask

    task test_async_reset;
        setCfg(16'd100, 16'd400, 16'd100, 16'd2, 16'd7, 1'b0);
        pulseStart();
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        checkCount++; if (axisIf.tvalid !== 1'b0) $display("[TB] FAIL areset_tvalid: got %b want 0", axisIf.tvalid); else passCount++;
        checkCount++; if (axisIf.tdata !== 16'd0) $display("[TB] FAIL areset_tdata: got %0d want 0", axisIf.tdata); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b want 0", busy); else passCount++;
        tick();
        reset = 1'b0;
        tick();
        setCfg(16'd100, 16'd400, 16'd100, 16'd2, 16'd0, 1'b0);
        pulseStart();
        captureSamples(40, 4'b1111);
        checkCount++; if (samples.size() !== 8) $display("[TB] FAIL post_reset_count: got %0d want 8", samples.size()); else passCount++;
        tick();
    endtask

`ifdef DDS_SWEEP_TRIANGLE_EN
    task test_triangle;
        logic [15:0] expTri[7] = '{16'd0, 16'd100, 16'd300, 16'd600, 16'd800, 16'd900, 16'd1100};
        setCfg(16'd100, 16'd300, 16'd100, 16'd1, 16'd0, 1'b1);
        pulseStart();
        tick();
        for (int i = 0; i < 7; i++) begin
            checkCount++;
            if (axisIf.tdata !== expTri[i]) $display("[TB] FAIL tri_phase[%0d]: got %0d want %0d", i, axisIf.tdata, expTri[i]);
            else passCount++;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        axisIf.tready = 1'b1;
        setCfg(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (2) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_basic_ramp();
        test_backpressure();
        test_continuous_wrap_abort();
        test_edge_cfg();
        test_async_reset();
`ifdef DDS_SWEEP_TRIANGLE_EN
        test_triangle();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
